stream_demux1to2: RTL and testbench

- 1-to-2 stream demultiplexer with valid/ready handshake. It is the routing counterpart of the 2:1 mux in the library: one input stream is steered to output a or output b.
- Select polarity matches the mux: in_sel=1 routes to a, in_sel=0 routes to b.
- Each output has its own DEPTH-entry FIFO, so a stalled consumer on one side does not block traffic to the other side.
- Per-output accepted-word counters are provided for debug and test.

---
 rtl/stream_demux1to2.sv | 129 ++++++++++++
 tb/tb_stream_demux1to2.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/stream_demux1to2.sv
// 1-to-2 stream demultiplexer: one valid/ready input steered to output a or b,
// each output buffered by its own FIFO so a stalled consumer never blocks the other side.
module stream_demux1to2 #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             in_ready,
  output logic             a_valid,
  output logic [WIDTH-1:0] a_data,
  input  logic             a_ready,
  output logic             b_valid,
  output logic [WIDTH-1:0] b_data,
  input  logic             b_ready,
  output logic [CNT_W-1:0] a_count,
  output logic [CNT_W-1:0] b_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);
  localparam logic [PtrW:0]   OccOne = (PtrW + 1)'(1);
  localparam logic [PtrW:0]   OccFull = (PtrW + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [WIDTH-1:0] a_mem_q [DEPTH];
  logic [WIDTH-1:0] b_mem_q [DEPTH];
  logic [PtrW-1:0]  a_wr_q, a_wr_d, a_rd_q, a_rd_d;
  logic [PtrW-1:0]  b_wr_q, b_wr_d, b_rd_q, b_rd_d;
  logic [PtrW:0]    a_occ_q, a_occ_d, b_occ_q, b_occ_d;
  logic [CNT_W-1:0] a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;

  logic a_full, b_full;
  logic a_push, b_push, a_pop, b_pop;

  assign a_full = (a_occ_q == OccFull);
  assign b_full = (b_occ_q == OccFull);

  // Ready depends only on the selected FIFO's fill state, never on the consumers' ready.
  assign in_ready = in_sel ? !a_full : !b_full;

  assign a_valid = (a_occ_q != '0);
  assign b_valid = (b_occ_q != '0);
  assign a_data  = a_mem_q[a_rd_q];
  assign b_data  = b_mem_q[b_rd_q];
  assign a_count = a_cnt_q;
  assign b_count = b_cnt_q;

  assign a_push = in_valid && in_ready && in_sel;
  assign b_push = in_valid && in_ready && !in_sel;
  assign a_pop  = a_valid && a_ready;
  assign b_pop  = b_valid && b_ready;

  always_comb begin
    a_wr_d  = a_wr_q;
    a_rd_d  = a_rd_q;
    a_occ_d = a_occ_q;
    a_cnt_d = a_cnt_q;
    if (a_push) begin
      a_wr_d  = a_wr_q + PtrOne;
      a_cnt_d = a_cnt_q + CntOne;
    end
    if (a_pop) begin
      a_rd_d = a_rd_q + PtrOne;
    end
    if (a_push && !a_pop) begin
      a_occ_d = a_occ_q + OccOne;
    end else if (!a_push && a_pop) begin
      a_occ_d = a_occ_q - OccOne;
    end
  end

  always_comb begin
    b_wr_d  = b_wr_q;
    b_rd_d  = b_rd_q;
    b_occ_d = b_occ_q;
    b_cnt_d = b_cnt_q;
    if (b_push) begin
      b_wr_d  = b_wr_q + PtrOne;
      b_cnt_d = b_cnt_q + CntOne;
    end
    if (b_pop) begin
      b_rd_d = b_rd_q + PtrOne;
    end
    if (b_push && !b_pop) begin
      b_occ_d = b_occ_q + OccOne;
    end else if (!b_push && b_pop) begin
      b_occ_d = b_occ_q - OccOne;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_wr_q  <= '0;
      a_rd_q  <= '0;
      a_occ_q <= '0;
      a_cnt_q <= '0;
      b_wr_q  <= '0;
      b_rd_q  <= '0;
      b_occ_q <= '0;
      b_cnt_q <= '0;
      // Storage is cleared so the data outputs read zero after reset.
      for (int unsigned i = 0; i < DEPTH; i++) begin
        a_mem_q[i] <= '0;
        b_mem_q[i] <= '0;
      end
    end else begin
      a_wr_q  <= a_wr_d;
      a_rd_q  <= a_rd_d;
      a_occ_q <= a_occ_d;
      a_cnt_q <= a_cnt_d;
      b_wr_q  <= b_wr_d;
      b_rd_q  <= b_rd_d;
      b_occ_q <= b_occ_d;
      b_cnt_q <= b_cnt_d;
      if (a_push) begin
        a_mem_q[a_wr_q] <= in_data;
      end
      if (b_push) begin
        b_mem_q[b_wr_q] <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_stream_demux1to2.sv
// Directed self-checking bench for stream_demux1to2; a second instance with a
// 3-bit counter shares the stimulus to check counter wrap.
module tb_stream_demux1to2;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_sel;
  logic       in_ready;
  logic       a_valid, b_valid;
  logic [7:0] a_data, b_data;
  logic       a_ready, b_ready;
  logic [15:0] a_count, b_count;

  logic       v_in_ready, v_a_valid, v_b_valid;
  logic [7:0] v_a_data, v_b_data;
  logic [2:0] v_a_count, v_b_count;

  int checks = 0;
  int errors = 0;

  stream_demux1to2 #(.WIDTH(8), .DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_sel(in_sel),
    .in_ready(in_ready), .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .a_count(a_count), .b_count(b_count)
  );

  stream_demux1to2 #(.WIDTH(8), .DEPTH(4), .CNT_W(3)) dut_c3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_sel(in_sel),
    .in_ready(v_in_ready), .a_valid(v_a_valid), .a_data(v_a_data), .a_ready(a_ready),
    .b_valid(v_b_valid), .b_data(v_b_data), .b_ready(b_ready),
    .a_count(v_a_count), .b_count(v_b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and land 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nxt;
    int got;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = 1'b0;
    a_ready = 1'b0; b_ready = 1'b0;
    #1;

    // Reset then idle
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_a_valid", a_valid, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_a_data", a_data, 0);
    chk("rst_b_data", b_data, 0);
    chk("rst_a_count", a_count, 0);
    chk("rst_b_count", b_count, 0);
    in_sel = 1'b1; #1;
    chk("rst_ready_sel1", in_ready, 1);
    in_sel = 1'b0; #1;
    chk("rst_ready_sel0", in_ready, 1);

    // Routing
    a_ready = 1'b1; b_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h11; in_sel = 1'b1;
    step();
    chk("route_a_valid1", a_valid, 1);
    chk("route_a_data1", a_data, 8'h11);
    chk("route_b_idle", b_valid, 0);
    in_data = 8'h22; in_sel = 1'b0;
    step();
    chk("route_a_drained", a_valid, 0);
    chk("route_b_valid", b_valid, 1);
    chk("route_b_data", b_data, 8'h22);
    in_data = 8'h33; in_sel = 1'b1;
    step();
    chk("route_a_data2", a_data, 8'h33);
    chk("route_b_drained", b_valid, 0);
    in_valid = 1'b0;
    step();
    chk("route_a_empty", a_valid, 0);
    chk("route_a_count", a_count, 2);
    chk("route_b_count", b_count, 1);

    // Wrap through b with toggling ready
    a_ready = 1'b0; b_ready = 1'b0;
    rst = 1'b1; step(); rst = 1'b0;
    nxt = 0; got = 0;
    for (int cyc = 0; cyc < 100 && got < 10; cyc++) begin
      in_valid = (nxt < 10);
      in_data  = 8'(nxt);
      in_sel   = 1'b0;
      b_ready  = (cyc % 2 == 1);
      #1;
      if (b_valid && b_ready) begin
        chk("wrap_order", b_data, got);
        got++;
      end
      if (in_valid && in_ready) nxt++;
      step();
    end
    in_valid = 1'b0; b_ready = 1'b0;
    chk("wrap_received", got, 10);
    chk("wrap_b_count", b_count, 10);
    chk("wrap_b_count_c3", v_b_count, 2);
    chk("wrap_a_count", a_count, 0);

    // Backpressure isolation
    rst = 1'b1; step(); rst = 1'b0;
    a_ready = 1'b0; b_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'h51 + 8'(i);
      #1;
      chk("bp_ready_fill", in_ready, 1);
      step();
    end
    in_data = 8'h55;
    #1;
    chk("bp_ready_full", in_ready, 0);
    chk("bp_a_count_full", a_count, 4);
    in_sel = 1'b0;
    #1;
    chk("bp_ready_other", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("bp_b_valid", b_valid, 1);
    chk("bp_b_data", b_data, 8'h55);
    chk("bp_b_count", b_count, 1);
    chk("bp_a_count_hold", a_count, 4);
    chk("bp_a_head", a_data, 8'h51);

    // Full plus pop: push refused even while popping
    a_ready = 1'b1; in_valid = 1'b1; in_sel = 1'b1; in_data = 8'h66;
    #1;
    chk("fp_ready_full", in_ready, 0);
    step();
    in_valid = 1'b0;
    chk("fp_ready_after", in_ready, 1);
    chk("fp_head", a_data, 8'h52);
    step();
    chk("fp_head2", a_data, 8'h53);
    step();
    chk("fp_head3", a_data, 8'h54);
    step();
    chk("fp_empty", a_valid, 0);
    chk("fp_a_count", a_count, 4);

    // Mid-traffic reset
    a_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'h71 + 8'(i);
      step();
    end
    in_valid = 1'b0;
    chk("mr_a_buffered", a_valid, 1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("mr_a_valid", a_valid, 0);
    chk("mr_a_data", a_data, 0);
    chk("mr_a_count", a_count, 0);
    chk("mr_b_valid", b_valid, 0);
    in_valid = 1'b1; in_sel = 1'b1; in_data = 8'h99;
    step();
    in_valid = 1'b0;
    chk("mr_new_valid", a_valid, 1);
    chk("mr_new_data", a_data, 8'h99);
    a_ready = 1'b1;
    step();
    chk("mr_new_drained", a_valid, 0);
    a_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
